// File: rtl/vending_sched.sv
// Two-slot vending controller: per-slot coin latches share one accumulator, granted round-robin.
// Dispenses at COST, then returns change as CHG-cent pulses; outputs are decoded from state/total.
module vending_sched #(
  parameter int COIN0 = 25,
  parameter int COIN1 = 10,
  parameter int COST  = 125,
  parameter int CHG   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_c0,
  input  logic       i_c1,
  output logic       o_d,
  output logic       o_chg,
  output logic       o_lost,
  output logic       o_busy,
  output logic [7:0] o_credit
);

  localparam int MAXC = (COIN0 > COIN1) ? COIN0 : COIN1;

  generate
    if (COIN0 < 1 || COIN0 > 255 || COIN1 < 1 || COIN1 > 255 ||
        COST < 1 || COST > 255 || CHG < 1 || CHG > 255 || COST + MAXC > 255) begin : g_bad_params
      $error("vending_sched: illegal parameters, need 1..255 and COST + max(COIN0, COIN1) <= 255");
    end
  endgenerate

  localparam logic [7:0] L_COIN0 = 8'(COIN0);
  localparam logic [7:0] L_COIN1 = 8'(COIN1);
  localparam logic [7:0] L_COST  = 8'(COST);
  localparam logic [7:0] L_CHG   = 8'(CHG);

  typedef enum logic [2:0] {S_INIT, S_WAIT, S_ADD, S_DISP, S_CHANGE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_total, w_total_nxt;
  logic       r_pend0, r_pend1;
  logic       r_ptr, w_ptr_nxt;
  logic       r_gnt, w_gnt_nxt;
  logic       r_lost;
  logic       w_d, w_chg;
  logic       w_cons0, w_cons1;

  // A slot's pending flag is consumed only by the ADD cycle granted to it.
  assign w_cons0 = (r_state == S_ADD) & ~r_gnt;
  assign w_cons1 = (r_state == S_ADD) &  r_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_total_nxt = r_total;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_d         = 1'b0;
    w_chg       = 1'b0;
    case (r_state)
      S_INIT: begin
        w_total_nxt = 8'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_total >= L_COST) begin
          w_state_nxt = S_DISP;
        end else if (r_pend0 | r_pend1) begin
          w_state_nxt = S_ADD;
          w_gnt_nxt   = (r_pend0 & r_pend1) ? r_ptr : r_pend1;
        end
      end
      S_ADD: begin
        w_total_nxt = r_total + (r_gnt ? L_COIN1 : L_COIN0);
        w_ptr_nxt   = ~r_gnt;
        w_state_nxt = S_WAIT;
      end
      S_DISP: begin
        w_d         = 1'b1;
        w_total_nxt = r_total - L_COST;
        w_state_nxt = S_CHANGE;
      end
      S_CHANGE: begin
        if (r_total >= L_CHG) begin
          w_chg       = 1'b1;
          w_total_nxt = r_total - L_CHG;
        end else begin
          w_state_nxt = S_INIT;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_total <= 8'd0;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_total <= w_total_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // A new pulse beats a same-cycle clear; a pulse onto an unconsumed pending flag is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_pend0 <= i_c0 | (r_pend0 & ~w_cons0);
      r_pend1 <= i_c1 | (r_pend1 & ~w_cons1);
      r_lost  <= (i_c0 & r_pend0 & ~w_cons0) | (i_c1 & r_pend1 & ~w_cons1);
    end
  end

  assign o_d      = w_d;
  assign o_chg    = w_chg;
  assign o_lost   = r_lost;
  assign o_busy   = (r_state != S_WAIT);
  assign o_credit = r_total;

endmodule

// File: tb/tb_vending_sched.sv
// Bench for vending_sched: a cycle-vector table, directed purchase/reset sequences,
// and random coin traffic against a purchase-level reference model.
module tb_vending_sched;

  localparam int COIN0 = 25;
  localparam int COIN1 = 10;
  localparam int COST  = 125;
  localparam int CHG   = 5;

  logic       i_clk, i_rst, i_c0, i_c1;
  logic       o_d, o_chg, o_lost, o_busy;
  logic [7:0] o_credit;

  vending_sched #(.COIN0(COIN0), .COIN1(COIN1), .COST(COST), .CHG(CHG)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_c0(i_c0), .i_c1(i_c1),
    .o_d(o_d), .o_chg(o_chg), .o_lost(o_lost), .o_busy(o_busy), .o_credit(o_credit)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cnt_d = 0;
  int cnt_chg = 0;

  // Reference model: phase of the purchase cycle, credit, pending coins and remaining change.
  localparam int P_INIT = 0, P_IDLE = 1, P_ADD = 2, P_DISP = 3, P_CHANGE = 4;
  int m_phase, m_credit, m_ptr, m_gnt, m_left;
  bit m_pend[2];
  bit m_lost;

  function automatic int coin_val(int k);
    return (k == 0) ? COIN0 : COIN1;
  endfunction

  task automatic model_step(input bit a, input bit b, input bit r);
    bit c[2];
    bit cons[2];
    bit np[2];
    if (r) begin
      m_phase = P_INIT; m_credit = 0; m_ptr = 0; m_gnt = 0; m_left = 0;
      m_pend[0] = 0; m_pend[1] = 0; m_lost = 0;
      return;
    end
    c[0] = a; c[1] = b;
    m_lost = 0;
    for (int k = 0; k < 2; k++) begin
      cons[k] = (m_phase == P_ADD) && (m_gnt == k);
      if (c[k] && m_pend[k] && !cons[k]) m_lost = 1;
      np[k] = c[k] ? 1'b1 : (cons[k] ? 1'b0 : m_pend[k]);
    end
    case (m_phase)
      P_INIT: begin m_credit = 0; m_phase = P_IDLE; end
      P_IDLE: begin
        if (m_credit >= COST) m_phase = P_DISP;
        else if (m_pend[0] || m_pend[1]) begin
          m_gnt = (m_pend[0] && m_pend[1]) ? m_ptr : (m_pend[0] ? 0 : 1);
          m_phase = P_ADD;
        end
      end
      P_ADD: begin
        m_credit = m_credit + coin_val(m_gnt);
        m_ptr = 1 - m_gnt;
        m_phase = P_IDLE;
      end
      P_DISP: begin
        m_credit = m_credit - COST;
        m_left = m_credit / CHG;
        m_phase = P_CHANGE;
      end
      default: begin
        if (m_left > 0) begin m_credit = m_credit - CHG; m_left--; end
        else m_phase = P_INIT;
      end
    endcase
    m_pend[0] = np[0]; m_pend[1] = np[1];
  endtask

  function automatic int model_out();
    int d, ch, bz;
    d  = (m_phase == P_DISP) ? 1 : 0;
    ch = (m_phase == P_CHANGE && m_left > 0) ? 1 : 0;
    bz = (m_phase != P_IDLE) ? 1 : 0;
    return (d << 11) | (ch << 10) | (int'(m_lost) << 9) | (bz << 8) | m_credit;
  endfunction

  function automatic int dut_out();
    return int'({o_d, o_chg, o_lost, o_busy, o_credit});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit a, input bit b, input bit r);
    @(negedge i_clk);
    i_c0 = a; i_c1 = b; i_rst = r;
    @(posedge i_clk);
    model_step(a, b, r);
    #1;
    chk("model{d,chg,lost,busy,credit}", dut_out(), model_out());
    if (o_d) cnt_d++;
    if (o_chg) cnt_chg++;
  endtask

  task automatic coin(input bit a, input bit b);
    cyc(a, b, 0); cyc(0, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin cyc(0, 0, 0); n++; end while (o_busy && n < 40);
    chk("idle_timeout_busy", int'(o_busy), 0);
  endtask

  typedef struct {
    logic       c0, c1;
    logic [7:0] credit;
    logic       busy, d, chg, lost;
  } vec_t;
  vec_t tbl[29];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1,   0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0,   0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0,  25, 0, 0, 0, 0};
    tbl[4]  = '{0, 0,  25, 1, 0, 0, 0};
    tbl[5]  = '{0, 0,  35, 0, 0, 0, 0};
    tbl[6]  = '{1, 0,  35, 0, 0, 0, 0};
    tbl[7]  = '{0, 0,  35, 1, 0, 0, 0};
    tbl[8]  = '{0, 0,  60, 0, 0, 0, 0};
    tbl[9]  = '{1, 1,  60, 0, 0, 0, 0};
    tbl[10] = '{0, 0,  60, 1, 0, 0, 0};
    tbl[11] = '{0, 0,  70, 0, 0, 0, 0};
    tbl[12] = '{0, 0,  70, 1, 0, 0, 0};
    tbl[13] = '{0, 0,  95, 0, 0, 0, 0};
    tbl[14] = '{1, 0,  95, 0, 0, 0, 0};
    tbl[15] = '{0, 0,  95, 1, 0, 0, 0};
    tbl[16] = '{1, 0, 120, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 120, 1, 0, 0, 0};
    tbl[18] = '{0, 0, 145, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 145, 1, 1, 0, 0};
    tbl[20] = '{1, 0,  20, 1, 0, 1, 0};
    tbl[21] = '{1, 0,  15, 1, 0, 1, 1};
    tbl[22] = '{0, 0,  10, 1, 0, 1, 0};
    tbl[23] = '{0, 0,   5, 1, 0, 1, 0};
    tbl[24] = '{0, 0,   0, 1, 0, 0, 0};
    tbl[25] = '{0, 0,   0, 1, 0, 0, 0};
    tbl[26] = '{0, 0,   0, 0, 0, 0, 0};
    tbl[27] = '{0, 0,   0, 1, 0, 0, 0};
    tbl[28] = '{0, 0,  25, 0, 0, 0, 0};

    i_rst = 1'b1; i_c0 = 1'b0; i_c1 = 1'b0;
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("reset_state", dut_out(), int'({1'b0, 1'b0, 1'b0, 1'b1, 8'd0}));

    // Round-robin order, set-wins in ADD, and a dropped coin during change return.
    for (int i = 0; i < 29; i++) begin
      cyc(tbl[i].c0, tbl[i].c1, 0);
      chk($sformatf("table[%0d]", i), dut_out(),
          int'({tbl[i].d, tbl[i].chg, tbl[i].lost, tbl[i].busy, tbl[i].credit}));
    end

    cyc(0, 0, 1); cyc(0, 0, 0);

    cnt_d = 0; cnt_chg = 0;
    for (int i = 0; i < 5; i++) begin
      coin(1, 0);
      chk($sformatf("exact_credit[%0d]", i), int'(o_credit), 25 * (i + 1));
    end
    wait_idle();
    chk("exact_d_count", cnt_d, 1);
    chk("exact_chg_count", cnt_chg, 0);
    chk("exact_credit_end", int'(o_credit), 0);

    cnt_d = 0; cnt_chg = 0;
    for (int i = 0; i < 4; i++) coin(1, 0);
    for (int i = 0; i < 3; i++) coin(0, 1);
    wait_idle();
    chk("over130_d_count", cnt_d, 1);
    chk("over130_chg_count", cnt_chg, 1);
    chk("over130_credit_end", int'(o_credit), 0);

    // 145 cents, then reset after the second change pulse.
    cnt_d = 0; cnt_chg = 0;
    for (int i = 0; i < 4; i++) coin(1, 0);
    coin(0, 1); coin(0, 1); coin(1, 0);
    chk("over145_credit", int'(o_credit), 145);
    begin
      int n;
      n = 0;
      while (cnt_chg < 2 && n < 20) begin cyc(0, 0, 0); n++; end
      chk("second_chg_seen", cnt_chg, 2);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    model_step(0, 0, 1);
    chk("async_reset_outputs", dut_out(), int'({1'b0, 1'b0, 1'b0, 1'b1, 8'd0}));
    cyc(0, 0, 1); cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    chk("no_chg_after_reset", cnt_chg, 2);
    chk("no_d_after_reset", cnt_d, 1);
    for (int i = 0; i < 5; i++) coin(1, 0);
    wait_idle();
    chk("purchase_after_reset_d", cnt_d, 2);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
